spi_responder: RTL and testbench

SPI mode-0 responder that lets the MCU (SPI initiator) exchange fixed-width frames with the FPGA fabric. All SPI pins are oversampled in the 24 MHz `clk` domain from `oscillator`. The block delivers each received frame to the core as a one-cycle strobe. It shifts a core-supplied word back out on `sdo` during the same frame.

---
 rtl/spi_pkg.sv | 13 +
 rtl/sync2.sv | 22 ++
 rtl/spi_responder.sv | 162 ++++++++++++++++
 tb/tb_spi_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder slice.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_state_t;

  localparam int unsigned SPI_DEFAULT_WIDTH = 8;
  localparam int unsigned SPI_SYNC_STAGES   = 2;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous pin; resets to RST_VAL.
module sync2
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SPI_SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ff <= {SPI_SYNC_STAGES{RST_VAL}};
    else        ff <= {ff[SPI_SYNC_STAGES-2:0], d};
  end

  assign q = ff[SPI_SYNC_STAGES-1];

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder, pins oversampled in the clk domain.
// Optional malformed-frame detection: define SPI_FRAME_CHECK_EN.
module spi_responder
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH = SPI_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             sdi,
  output logic             sdo,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_err
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic sclk_s, cs_s, sdi_s;
  logic sclk_q, cs_q;
  logic [SPI_SYNC_STAGES-1:0] settle;
  logic armed;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  spi_state_t state_q, state_d;

  logic [WIDTH-1:0] tx_buf;
  logic [WIDTH-1:0] shift_reg;
  logic             rx_bit;
  logic [CNT_W-1:0] bit_cnt;
  logic             last_bit;

  logic             start_c, sample_c, shift_c, capture_c, err_c, buf_we_c;
  logic [WIDTH-1:0] load_word_c;

  sync2 #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .reset(reset), .d(cs_n), .q(cs_s));
  sync2 #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .reset(reset), .d(sclk), .q(sclk_s));
  sync2 #(.RST_VAL(1'b0)) u_sync_sdi  (.clk(clk), .reset(reset), .d(sdi),  .q(sdi_s));

  // Previous-cycle samples for edge detection; chip select is only armed once
  // a real (post-synchronizer) high level has been observed after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_q <= 1'b0;
      cs_q   <= 1'b1;
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      sclk_q <= sclk_s;
      cs_q   <= cs_s;
      settle <= {settle[SPI_SYNC_STAGES-2:0], 1'b1};
      if ((&settle) && cs_s) armed <= 1'b1;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_rise   = cs_s & ~cs_q;
  assign cs_fall   = armed & cs_q & ~cs_s;
  assign last_bit  = (bit_cnt == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cs_fall) state_d = SHIFT;
      SHIFT: begin
        if (cs_rise)                    state_d = IDLE;
        else if (sclk_rise && last_bit) state_d = DONE;
      end
      DONE:    if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath controls decoded from state and synchronized pin events.
  always_comb begin
    start_c     = 1'b0;
    sample_c    = 1'b0;
    shift_c     = 1'b0;
    capture_c   = 1'b0;
    buf_we_c    = 1'b0;
    load_word_c = tx_load ? tx_data : tx_buf;
    unique case (state_q)
      IDLE: begin
        start_c  = cs_fall;
        buf_we_c = cs_fall | tx_load;
      end
      SHIFT: begin
        if (!cs_rise) begin
          sample_c  = sclk_rise;
          shift_c   = sclk_fall;
          capture_c = sclk_rise & last_bit;
        end
      end
      default: ;
    endcase
  end

`ifdef SPI_FRAME_CHECK_EN
  assign err_c = ((state_q == SHIFT) && cs_rise && (bit_cnt != '0)) ||
                 ((state_q == DONE) && sclk_rise);
`else
  assign err_c = 1'b0;
`endif

  assign tx_ready = (state_q == IDLE);

  // Transmit buffer: written from tx_data in IDLE, cleared when a frame starts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        tx_buf <= '0;
    else if (buf_we_c) tx_buf <= start_c ? '0 : tx_data;
  end

  // Received bit is parked until the following falling edge shifts it in,
  // so the outgoing word is never overwritten before it leaves on sdo.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
      rx_bit    <= 1'b0;
      bit_cnt   <= '0;
      sdo       <= 1'b0;
    end else begin
      if (start_c)      shift_reg <= load_word_c;
      else if (shift_c) shift_reg <= {shift_reg[WIDTH-2:0], rx_bit};

      if (sample_c) rx_bit <= sdi_s;

      if (start_c)       bit_cnt <= '0;
      else if (sample_c) bit_cnt <= bit_cnt + CNT_W'(1);

      if (start_c)                sdo <= load_word_c[WIDTH-1];
      else if (shift_c)           sdo <= shift_reg[WIDTH-2];
      else if (state_d != SHIFT)  sdo <= 1'b0;
    end
  end

  // Completed frame register and one-cycle strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (capture_c) rx_data <= {shift_reg[WIDTH-2:0], sdi_s};
      rx_valid  <= capture_c;
      frame_err <= err_c;
    end
  end

endmodule

// File: tb/tb_spi_responder.sv
// Self-checking bench for spi_responder (WIDTH=8): vector table, hand-written
// reset sequences and randomized frames checked against a frame-level model.
module tb_spi_responder;

  localparam int unsigned W = 8;

`ifdef SPI_FRAME_CHECK_EN
  localparam int CHK_EN = 1;
`else
  localparam int CHK_EN = 0;
`endif

  logic         clk = 1'b0;
  logic         reset, sclk, cs_n, sdi, sdo, tx_load, tx_ready, rx_valid, frame_err;
  logic [W-1:0] tx_data, rx_data;

  int n_cmp = 0;
  int n_bad = 0;
  int rv_cnt = 0;
  int fe_cnt = 0;

  logic [7:0] m_buf;
  logic [7:0] m_rx;

  typedef struct {
    bit         pre_load;
    bit         sim_load;
    logic [7:0] tx;
    logic [7:0] mosi;
    int         nbits;
    int         extra;
    bit         mid_load;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    int         exp_valid;
    int         exp_err;
  } vec_t;

  vec_t vecs[10];

  spi_responder #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .sdi(sdi), .sdo(sdo),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err)
  );

  always #21 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rx_valid === 1'b1)  rv_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic sclk_pulse();
    sclk = 1'b1;
    cycles(4);
    sclk = 1'b0;
    cycles(4);
  endtask

  task automatic run_frame(input logic [7:0] mosi, input int nbits, input int extra,
                           input bit sim_load, input logic [7:0] tx, input bit mid_load,
                           output logic [7:0] miso, output int rv_lat);
    miso   = '0;
    rv_lat = -1;
    @(negedge clk);
    cs_n = 1'b0;
    if (sim_load) begin
      tx_data = tx;
      tx_load = 1'b1;
    end
    cycles(4);
    tx_load = 1'b0;
    cycles(2);
    for (int i = 0; i < nbits; i++) begin
      sdi = mosi[7-i];
      for (int j = 0; j < 4; j++) begin
        if (mid_load && i == 3 && j == 0) begin
          tx_data = 8'hFF;
          tx_load = 1'b1;
        end
        @(negedge clk);
        if (mid_load && i == 3 && j == 0) begin
          check("tx_ready_in_shift", 32'(tx_ready), 32'd0);
          tx_load = 1'b0;
        end
      end
      miso[7-i] = sdo;
      sclk = 1'b1;
      cycles(4);
      if (i == nbits - 1) rv_lat = rv_cnt;
      sclk = 1'b0;
    end
    cycles(4);
    for (int e = 0; e < extra; e++) begin
      check("sdo_in_done", 32'(sdo), 32'd0);
      sclk_pulse();
    end
    cs_n = 1'b1;
    sdi  = 1'b0;
    cycles(6);
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    int rv0, fe0, lat;
    logic [7:0] miso;
    rv0 = rv_cnt;
    fe0 = fe_cnt;
    if (v.pre_load) load(v.tx);
    run_frame(v.mosi, v.nbits, v.extra, v.sim_load, v.tx, v.mid_load, miso, lat);
    check({tag, "_sdo_bits"}, 32'(miso), 32'(v.exp_miso));
    check({tag, "_rx_data"}, 32'(rx_data), 32'(v.exp_rx));
    check({tag, "_rx_valid_pulses"}, 32'(rv_cnt - rv0), 32'(v.exp_valid));
    check({tag, "_frame_err_pulses"}, 32'(fe_cnt - fe0), 32'(v.exp_err * CHK_EN));
    check({tag, "_tx_ready_idle"}, 32'(tx_ready), 32'd1);
    check({tag, "_sdo_idle"}, 32'(sdo), 32'd0);
    if (v.exp_valid != 0) check({tag, "_rx_valid_latency"}, 32'(lat - rv0), 32'd1);
  endtask

  initial begin
    vec_t       rv;
    int         rv0, fe0, nb;
    logic [7:0] mask;

    reset = 1'b0; cs_n = 1'b1; sclk = 1'b0; sdi = 1'b0; tx_load = 1'b0; tx_data = '0;

    //                pre sim tx     mosi   nb ex mid exp_miso exp_rx v e
    vecs[0] = '{1'b1, 1'b0, 8'hA5, 8'h3C, 8, 0, 1'b0, 8'hA5, 8'h3C, 1, 0};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 8'h81, 8, 0, 1'b0, 8'h00, 8'h81, 1, 0};
    vecs[2] = '{1'b1, 1'b0, 8'h5C, 8'h96, 8, 0, 1'b1, 8'h5C, 8'h96, 1, 0};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 8'h0F, 8, 0, 1'b0, 8'h00, 8'h0F, 1, 0};
    vecs[4] = '{1'b1, 1'b0, 8'h77, 8'hE7, 5, 0, 1'b0, 8'h70, 8'h0F, 0, 1};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 8'h24, 8, 0, 1'b0, 8'h00, 8'h24, 1, 0};
    vecs[6] = '{1'b0, 1'b1, 8'hC3, 8'h99, 8, 0, 1'b0, 8'hC3, 8'h99, 1, 0};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 8'h42, 8, 1, 1'b0, 8'h00, 8'h42, 1, 1};
    vecs[8] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8, 0, 1'b0, 8'hFF, 8'h00, 1, 0};
    vecs[9] = '{1'b1, 1'b0, 8'h01, 8'hFF, 8, 0, 1'b0, 8'h01, 8'hFF, 1, 0};

    cycles(3);
    check("por_sdo", 32'(sdo), 32'd0);
    check("por_tx_ready", 32'(tx_ready), 32'd1);
    check("por_rx_data", 32'(rx_data), 32'd0);
    check("por_rx_valid", 32'(rx_valid), 32'd0);
    check("por_frame_err", 32'(frame_err), 32'd0);
    reset = 1'b1;
    cycles(6);

    for (int k = 0; k < 10; k++) apply_vec($sformatf("vec%0d", k), vecs[k]);

    // Reset mid-frame with a pending load, released while cs_n is still low.
    load(8'h33);
    rv0 = rv_cnt;
    fe0 = fe_cnt;
    @(negedge clk);
    cs_n = 1'b0;
    sdi  = 1'b1;
    cycles(6);
    sclk_pulse();
    sclk_pulse();
    reset = 1'b0;
    cycles(2);
    check("rst_sdo", 32'(sdo), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    reset = 1'b1;
    for (int p = 0; p < 6; p++) sclk_pulse();
    cs_n = 1'b1;
    sdi  = 1'b0;
    cycles(6);
    check("rst_partial_no_valid", 32'(rv_cnt - rv0), 32'd0);
    check("rst_partial_no_err", 32'(fe_cnt - fe0), 32'd0);
    check("rst_partial_rx_data", 32'(rx_data), 32'd0);
    rv = '{1'b0, 1'b0, 8'h00, 8'h5A, 8, 0, 1'b0, 8'h00, 8'h5A, 1, 0};
    apply_vec("post_rst", rv);

    // Randomized frames against the frame-level model.
    m_buf = 8'h00;
    m_rx  = 8'h5A;
    for (int k = 0; k < 24; k++) begin
      rv.pre_load = 1'($urandom_range(0, 1));
      rv.sim_load = 1'b0;
      rv.tx       = 8'($urandom);
      rv.mosi     = 8'($urandom);
      nb          = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 8;
      rv.nbits    = nb;
      rv.extra    = 0;
      rv.mid_load = 1'b0;
      if (rv.pre_load) m_buf = rv.tx;
      mask        = 8'(8'hFF << (8 - nb));
      rv.exp_miso = m_buf & mask;
      m_buf       = 8'h00;
      if (nb == 8) m_rx = rv.mosi;
      rv.exp_rx    = m_rx;
      rv.exp_valid = (nb == 8) ? 1 : 0;
      rv.exp_err   = (nb == 8) ? 0 : 1;
      apply_vec($sformatf("rnd%0d", k), rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
